bam_generator: RTL and testbench
================================

// Module: bam_generator
// PURPOSE
//  Bit-angle-modulation (BAM) source for the GPIO alternate-output path. It is
//  register-mapped to the MIPS core: the ALU writes the duty value and control word.
//  o_BAM drives GPIO i_ALT_IN, and o_ALT drives GPIO i_ALT.
//  Each frame shows bit k of the duty value for 2^k time units, LSB first.
// PARAMETERS
//  WIDTH    8   BAM resolution in bits; frame = 2^WIDTH-1 units
//  PRESC_W  16  prescaler width; PRESC_W <= 16
// PORTS
//  i_clk      in   1      system clock
//  i_arst     in   1      asynchronous active-high reset
//  i_DATA     in   32     write data from ALU
//  i_VAL_WE   in   1      write VAL <= i_DATA[WIDTH-1:0]
//  i_CTRL_WE  in   1      write CTRL: [0] EN, [1] ALT, [PRESC_W+15:16] PRESC
//  o_BAM      out  1      BAM waveform (to GPIO i_ALT_IN)
//  o_ALT      out  1      alternate-output enable (to GPIO i_ALT)
//  o_FRAME    out  1      one-cycle pulse on the last cycle of each frame
//  o_STATUS   out  32     [0] running, [1] ALT, [15:8] bit_idx (zero-ext), [31:16] frame_cnt
// BEHAVIOUR
//  - Interface: reset i_arst, asynchronous, active-high; clock i_clk. All state is
//    clocked on posedge i_clk.
//  - Reset: VAL, CTRL, shadows, counters = 0; state IDLE.
//    o_BAM = 0, o_ALT = 0, o_FRAME = 0, o_STATUS = 0.
//    Reset asserted mid-frame aborts the frame at once.
//  - All outputs decode from flops only. There is no combinational path from inputs.
//  - State IDLE: o_BAM = 0, prescaler frozen. When CTRL.EN = 1, go to LOAD.
//  - State LOAD (1 cycle): sh_val <= VAL, sh_presc <= PRESC, bit_idx <= 0,
//    slot <= 0, pcnt <= 0. Then go to RUN.
//  - State RUN: o_BAM = sh_val[bit_idx].
//    - tick = (pcnt == sh_presc). On tick pcnt <= 0, otherwise pcnt++.
//    - On tick with slot == 2^bit_idx - 1: slot <= 0.
//      - If bit_idx < WIDTH-1: bit_idx++.
//      - Else, end of frame: o_FRAME = 1 this cycle, frame_cnt++ (wraps 0xFFFF -> 0),
//        bit_idx <= 0, sh_val <= VAL, sh_presc <= PRESC. Stay in RUN.
//    - On any other tick: slot++.
//  - Timing: frame = (2^WIDTH-1)*(sh_presc+1) cycles. High time = sh_val*(sh_presc+1) cycles.
//  - VAL/PRESC writes mid-frame do not affect the current frame; they apply at the
//    next frame boundary.
//  - Write on the same edge as the frame boundary: shadows take the OLD value; the
//    new value applies one frame later.
//  - CTRL.EN cleared while in RUN: the next edge goes to IDLE and o_BAM = 0;
//    frame_cnt is kept. Re-enable restarts via LOAD at bit 0.
//  - o_ALT = CTRL.ALT, independent of EN. With ALT = 1 and EN = 0, GPIO sees a
//    steady 0.
//  - VAL = 0: low for the whole frame. VAL = 2^WIDTH-1: high for the whole frame.
//    PRESC = 0: one tick per cycle.
//  - Write enables asserted in the same cycle are independent; both registers update.
// TESTING
//  1 Assert i_arst mid-run -> o_BAM=0, o_ALT=0, o_FRAME=0, o_STATUS=0 immediately;
//    the bench checks that no clock is needed.
//  2 VAL=0x05, PRESC=0, EN=1 -> after LOAD: high 1, low 2, high 4, then low 248 cycles.
//    o_FRAME repeats every 255 cycles.
//  3 VAL=0x80, PRESC=3 -> low 508 cycles, then high 512; frame = 1020 cycles.
//  4 VAL=0x00 running, write VAL=0xFF mid-frame -> rest of frame low, next frame all high.
//    frame_cnt increments by 1 per o_FRAME.
//  5 Write VAL=0x0F in the same cycle as o_FRAME -> next frame uses the old VAL,
//    the following frame uses 0x0F.
//  6 Clear EN mid-frame -> next cycle o_BAM=0, status[0]=0. Re-set EN -> bit_idx=0 after LOAD.
//    Write CTRL=0x2 -> o_ALT=1 while o_BAM stays 0.

Source files
------------

// File: rtl/bam_generator.sv
// Bit-angle-modulation source for the GPIO alternate-output path: bit k of the duty
// value is shown for 2^k prescaled units per frame, LSB first; outputs decode from flops only.
module bam_generator #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 16
) (
    input  logic        i_clk,
    input  logic        i_arst,
    input  logic [31:0] i_DATA,
    input  logic        i_VAL_WE,
    input  logic        i_CTRL_WE,
    output logic        o_BAM,
    output logic        o_ALT,
    output logic        o_FRAME,
    output logic [31:0] o_STATUS
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t               state;
    logic [WIDTH-1:0]     val;
    logic                 en;
    logic                 alt;
    logic [PRESC_W-1:0]   presc;
    logic [WIDTH-1:0]     sh_val;
    logic [PRESC_W-1:0]   sh_presc;
    logic [PRESC_W-1:0]   pcnt;
    logic [BW-1:0]        bit_idx;
    logic [WIDTH-1:0]     slot;
    logic [15:0]          frame_cnt;

    logic tick;
    logic slot_end;
    logic last_bit;
    logic frame_end;
    logic unused_data;

    // Only some of the 32 data bits map onto registers.
    assign unused_data = ^i_DATA;

    assign tick      = (pcnt == sh_presc);
    assign slot_end  = (slot == ((WIDTH'(1) << bit_idx) - WIDTH'(1)));
    assign last_bit  = (bit_idx == BW'(WIDTH - 1));
    assign frame_end = (state == RUN) && en && tick && slot_end && last_bit;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            val   <= '0;
            en    <= 1'b0;
            alt   <= 1'b0;
            presc <= '0;
        end else begin
            if (i_VAL_WE) begin
                val <= i_DATA[WIDTH-1:0];
            end
            if (i_CTRL_WE) begin
                en    <= i_DATA[0];
                alt   <= i_DATA[1];
                presc <= i_DATA[16 +: PRESC_W];
            end
        end
    end

    // Shadows are only reloaded at LOAD and at the frame boundary, so register
    // writes landing on the boundary edge are seen one frame later.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state     <= IDLE;
            sh_val    <= '0;
            sh_presc  <= '0;
            pcnt      <= '0;
            bit_idx   <= '0;
            slot      <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    sh_val   <= val;
                    sh_presc <= presc;
                    bit_idx  <= '0;
                    slot     <= '0;
                    pcnt     <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (tick) begin
                        pcnt <= '0;
                        if (slot_end) begin
                            slot <= '0;
                            if (!last_bit) begin
                                bit_idx <= bit_idx + BW'(1);
                            end else begin
                                bit_idx   <= '0;
                                frame_cnt <= frame_cnt + 16'd1;
                                sh_val    <= val;
                                sh_presc  <= presc;
                            end
                        end else begin
                            slot <= slot + WIDTH'(1);
                        end
                    end else begin
                        pcnt <= pcnt + PRESC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_BAM    = (state == RUN) && sh_val[bit_idx];
    assign o_ALT    = alt;
    assign o_FRAME  = frame_end;
    assign o_STATUS = {frame_cnt, 8'(bit_idx), 6'd0, alt, (state != IDLE)};

endmodule

// File: tb/tb_bam_generator.sv
// Bench for bam_generator: every cycle is compared against a frame-position model
// (time within frame -> unit -> bit), plus directed period, boundary and reset checks.
module tb_bam_generator;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 16;
    localparam int LEN     = (1 << WIDTH) - 1;

    logic        i_clk = 1'b0;
    logic        i_arst = 1'b0;
    logic [31:0] i_DATA = '0;
    logic        i_VAL_WE = 1'b0;
    logic        i_CTRL_WE = 1'b0;
    logic        o_BAM;
    logic        o_ALT;
    logic        o_FRAME;
    logic [31:0] o_STATUS;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 loading, 2 running; m_t is the cycle offset within the frame.
    int m_mode, m_val, m_presc, m_sv, m_sp, m_t, m_fc, m_k_stale;
    bit m_en, m_alt;

    always #5 i_clk = ~i_clk;

    bam_generator #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .i_clk    (i_clk),
        .i_arst   (i_arst),
        .i_DATA   (i_DATA),
        .i_VAL_WE (i_VAL_WE),
        .i_CTRL_WE(i_CTRL_WE),
        .o_BAM    (o_BAM),
        .o_ALT    (o_ALT),
        .o_FRAME  (o_FRAME),
        .o_STATUS (o_STATUS)
    );

    function automatic int floor_log2(input int x);
        int k = 0;
        while ((2 << k) <= x) k++;
        return k;
    endfunction

    function automatic int cur_bit();
        return floor_log2(m_t / (m_sp + 1) + 1);
    endfunction

    function automatic logic exp_bam();
        if (m_mode != 2) return 1'b0;
        return 1'((m_sv >> cur_bit()) & 1);
    endfunction

    function automatic logic exp_frame();
        return (m_mode == 2) && m_en && (m_t == LEN * (m_sp + 1) - 1);
    endfunction

    function automatic logic [31:0] exp_status();
        int k;
        k = (m_mode == 2) ? cur_bit() : m_k_stale;
        return {16'(m_fc), 8'(k), 6'd0, m_alt, (m_mode != 0)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_val = 0; m_presc = 0; m_sv = 0; m_sp = 0;
        m_t = 0; m_fc = 0; m_k_stale = 0; m_en = 0; m_alt = 0;
    endtask

    task automatic model_edge(input bit vwe, input bit cwe, input logic [31:0] d);
        case (m_mode)
            0: if (m_en) m_mode = 1;
            1: begin
                m_mode = 2; m_sv = m_val; m_sp = m_presc; m_t = 0;
            end
            default: begin
                if (!m_en) begin
                    m_k_stale = cur_bit();
                    m_mode = 0;
                end else if (m_t == LEN * (m_sp + 1) - 1) begin
                    m_fc = (m_fc + 1) % 65536;
                    m_t = 0; m_sv = m_val; m_sp = m_presc;
                end else begin
                    m_t++;
                end
            end
        endcase
        if (vwe) m_val = int'(d[WIDTH-1:0]);
        if (cwe) begin
            m_en = d[0]; m_alt = d[1]; m_presc = int'(d[31:16]);
        end
    endtask

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        check1("bam", 32'(o_BAM), 32'(exp_bam()));
        check1("frame", 32'(o_FRAME), 32'(exp_frame()));
        check1("alt", 32'(o_ALT), 32'(m_alt));
        check1("status", o_STATUS, exp_status());
    endtask

    task automatic step(input bit vwe, input bit cwe, input logic [31:0] d);
        i_VAL_WE = vwe; i_CTRL_WE = cwe; i_DATA = d;
        @(posedge i_clk);
        model_edge(vwe, cwe, d);
        #1;
        i_VAL_WE = 1'b0; i_CTRL_WE = 1'b0; i_DATA = '0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'd0);
    endtask

    function automatic logic [31:0] ctrl(input bit en, input bit alt, input int presc);
        return {16'(presc), 14'd0, alt, en};
    endfunction

    // Called between edges: reset must clear outputs with no clock edge in between.
    task automatic async_reset();
        #2;
        i_arst = 1'b1;
        #1;
        model_reset();
        check1("rst_bam", 32'(o_BAM), 32'd0);
        check1("rst_alt", 32'(o_ALT), 32'd0);
        check1("rst_frame", 32'(o_FRAME), 32'd0);
        check1("rst_status", o_STATUS, 32'd0);
        #1;
        i_arst = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (!exp_frame() && n < 5000) begin
            step(1'b0, 1'b0, 32'd0);
            n++;
        end
        check1(tag, 32'(o_FRAME), 32'd1);
    endtask

    // Assumes the current cycle carries a frame pulse; counts cycles to the next one.
    task automatic measure_period(input string tag, input int expected);
        int n;
        step(1'b0, 1'b0, 32'd0);
        n = 1;
        while (o_FRAME !== 1'b1 && n < 5000) begin
            step(1'b0, 1'b0, 32'd0);
            n++;
        end
        check1(tag, 32'(n), 32'(expected));
    endtask

    initial begin
        model_reset();
        async_reset();
        idle(3);

        // VAL=0x05, PRESC=0: high 1, low 2, high 4, low 248.
        step(1'b1, 1'b0, 32'h0000_0005);
        step(1'b0, 1'b1, ctrl(1'b1, 1'b0, 0));
        wait_frame("t2_frame");
        measure_period("t2_period", 255);
        measure_period("t2_period2", 255);

        // VAL=0x80, PRESC=3: new values take effect at the next boundary.
        step(1'b1, 1'b0, 32'h0000_0080);
        step(1'b0, 1'b1, ctrl(1'b1, 1'b0, 3));
        wait_frame("t3_frame");
        measure_period("t3_period", 1020);
        measure_period("t3_period2", 1020);

        // VAL=0 running, then 0xFF written mid-frame.
        step(1'b1, 1'b0, 32'h0000_0000);
        step(1'b0, 1'b1, ctrl(1'b1, 1'b0, 0));
        wait_frame("t4_frame_a");
        idle(60);
        step(1'b1, 1'b0, 32'h0000_00FF);
        wait_frame("t4_frame_b");
        measure_period("t4_period", 255);

        // Write coinciding with the frame boundary: old value used for one more frame.
        step(1'b1, 1'b0, 32'h0000_0003);
        wait_frame("t5_frame_a");
        step(1'b1, 1'b0, 32'h0000_000F);
        wait_frame("t5_frame_b");
        measure_period("t5_period", 255);

        // EN cleared mid-frame, re-enabled, then ALT alone.
        idle(37);
        step(1'b0, 1'b1, ctrl(1'b0, 1'b0, 0));
        step(1'b0, 1'b0, 32'd0);
        check1("t6_bam_off", 32'(o_BAM), 32'd0);
        check1("t6_running", 32'(o_STATUS[0]), 32'd0);
        idle(5);
        step(1'b0, 1'b1, ctrl(1'b1, 1'b0, 0));
        idle(2);
        check1("t6_bit_idx", 32'(o_STATUS[15:8]), 32'd0);
        idle(5);
        step(1'b0, 1'b1, 32'h0000_0002);
        idle(4);
        check1("t6_alt", 32'(o_ALT), 32'd1);
        check1("t6_alt_bam", 32'(o_BAM), 32'd0);

        // Randomized register traffic, including simultaneous writes.
        step(1'b0, 1'b1, ctrl(1'b1, 1'b0, 0));
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [31:0] d;
            r = int'($urandom_range(0, 199));
            d = $urandom;
            if (r == 0) begin
                d[31:16] = 16'($urandom_range(0, 2));
                d[0] = ($urandom_range(0, 3) != 0);
                step(1'b0, 1'b1, d);
            end else if (r < 4) begin
                step(1'b1, 1'b0, d);
            end else if (r == 4) begin
                d[31:16] = 16'($urandom_range(0, 1));
                d[0] = 1'b1;
                step(1'b1, 1'b1, d);
            end else begin
                step(1'b0, 1'b0, 32'd0);
            end
        end

        // Reset in the middle of a running frame.
        step(1'b1, 1'b0, 32'h0000_00A5);
        step(1'b0, 1'b1, ctrl(1'b1, 1'b1, 0));
        idle(300);
        async_reset();
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
